// File: rtl/gridx_lsu_pkg.sv
// Shared types and defaults for the core LSU-to-L1 memory arbiter.
package gridx_lsu_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 15;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } lsu_arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } lsu_op_t;

    // A single lane still needs a one-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_lsu_mem_arbiter_rr_picker.sv
// Combinational round-robin search: first eligible lane at or after ptr,
// wrapping modulo THREADS (also for non-power-of-two lane counts).
module rr_picker
    import gridx_lsu_pkg::*;
#(
    parameter int THREADS = 4,
    parameter int PTR_W   = ptr_width(THREADS)
) (
    input  logic [THREADS-1:0] eligible,
    input  logic [PTR_W-1:0]   ptr,
    output logic               found,
    output logic [PTR_W-1:0]   index
);

    // Scan lanes starting at the pointer; the first hit wins.
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        found    = 1'b0;
        index    = ptr;
        cand     = 0;
        cand_idx = {PTR_W{1'b0}};
        for (int i = 0; i < THREADS; i++) begin
            cand     = (int'(ptr) + i) % THREADS;
            cand_idx = PTR_W'(cand);
            if (!found && eligible[cand_idx]) begin
                found = 1'b1;
                index = cand_idx;
            end else begin
                index = index;
            end
        end
    end

endmodule

// File: rtl/core_lsu_mem_arbiter.sv
// Round-robin arbiter from per-thread LSU lanes to the single-port L1.
// Optional watchdog on the L1 response: define CORE_LSU_ARB_TIMEOUT_EN.
module core_lsu_mem_arbiter
    import gridx_lsu_pkg::*;
#(
    parameter int THREADS        = 4,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [THREADS-1:0]               lsu_read_valid,
    input  logic [THREADS*ADDR_WIDTH-1:0]    lsu_read_address,
    input  logic [THREADS-1:0]               lsu_write_valid,
    input  logic [THREADS*ADDR_WIDTH-1:0]    lsu_write_address,
    input  logic [THREADS*DATA_WIDTH-1:0]    lsu_write_data,
    output logic [THREADS-1:0]               lsu_read_ready,
    output logic [THREADS*DATA_WIDTH-1:0]    lsu_read_data,
    output logic [THREADS-1:0]               lsu_write_ready,
    output logic                             mem_read_valid,
    output logic [ADDR_WIDTH-1:0]            mem_read_address,
    output logic                             mem_write_valid,
    output logic [ADDR_WIDTH-1:0]            mem_write_address,
    output logic [DATA_WIDTH-1:0]            mem_write_data,
`ifdef CORE_LSU_ARB_TIMEOUT_EN
    output logic                             mem_timeout_err,
`endif
    input  logic                             mem_read_ready,
    input  logic [DATA_WIDTH-1:0]            mem_read_data,
    input  logic                             mem_write_ready
);

    localparam int PTR_W = ptr_width(THREADS);

    lsu_arb_state_t    state_r;
    lsu_arb_state_t    next_state_s;
    lsu_op_t           op_r;
    logic [PTR_W-1:0]  lane_r;
    logic [PTR_W-1:0]  ptr_r;
    logic [THREADS-1:0] eligible_s;
    logic              found_s;
    logic [PTR_W-1:0]  pick_s;
    logic              match_s;
    logic              timeout_s;
    logic              done_s;
    logic              release_s;

    assign eligible_s = (lsu_read_valid | lsu_write_valid) & ~(lsu_read_ready | lsu_write_ready);
    assign match_s    = (op_r == OP_READ) ? mem_read_ready : mem_write_ready;
    assign done_s     = match_s | timeout_s;
    assign release_s  = (op_r == OP_READ) ? !lsu_read_valid[lane_r] : !lsu_write_valid[lane_r];

    rr_picker #(
        .THREADS (THREADS),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .eligible (eligible_s),
        .ptr      (ptr_r),
        .found    (found_s),
        .index    (pick_s)
    );

`ifdef CORE_LSU_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_r;

    assign timeout_s = (state_r == WAIT) && !match_s && (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive WAIT cycles without the matching L1 ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if ((state_r == WAIT) && !match_s) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= {WD_W{1'b0}};
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_timeout_err <= 1'b0;
        end else if (timeout_s) begin
            mem_timeout_err <= 1'b1;
        end else begin
            mem_timeout_err <= mem_timeout_err;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (found_s)   next_state_s = ISSUE;   else next_state_s = IDLE;
            ISSUE:   next_state_s = WAIT;
            WAIT:    if (done_s)    next_state_s = RESPOND; else next_state_s = WAIT;
            RESPOND: if (release_s) next_state_s = IDLE;    else next_state_s = RESPOND;
            default: next_state_s = IDLE;
        endcase
    end

    // Grant latch, one-cycle L1 strobes, held LSU responses and pointer update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r              <= OP_READ;
            lane_r            <= {PTR_W{1'b0}};
            ptr_r             <= {PTR_W{1'b0}};
            mem_read_valid    <= 1'b0;
            mem_write_valid   <= 1'b0;
            mem_read_address  <= {ADDR_WIDTH{1'b0}};
            mem_write_address <= {ADDR_WIDTH{1'b0}};
            mem_write_data    <= {DATA_WIDTH{1'b0}};
            lsu_read_ready    <= {THREADS{1'b0}};
            lsu_write_ready   <= {THREADS{1'b0}};
            lsu_read_data     <= {(THREADS*DATA_WIDTH){1'b0}};
        end else begin
            mem_read_valid  <= 1'b0;
            mem_write_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        lane_r <= pick_s;
                        // A lane asking for both gets its write served first.
                        if (lsu_write_valid[pick_s]) begin
                            op_r              <= OP_WRITE;
                            mem_write_valid   <= 1'b1;
                            mem_write_address <= lsu_write_address[pick_s*ADDR_WIDTH +: ADDR_WIDTH];
                            mem_write_data    <= lsu_write_data[pick_s*DATA_WIDTH +: DATA_WIDTH];
                        end else begin
                            op_r              <= OP_READ;
                            mem_read_valid    <= 1'b1;
                            mem_read_address  <= lsu_read_address[pick_s*ADDR_WIDTH +: ADDR_WIDTH];
                        end
                    end
                end
                WAIT: begin
                    if (done_s) begin
                        if (op_r == OP_READ) begin
                            lsu_read_ready[lane_r] <= 1'b1;
                            lsu_read_data[lane_r*DATA_WIDTH +: DATA_WIDTH] <=
                                timeout_s ? {DATA_WIDTH{1'b0}} : mem_read_data;
                        end else begin
                            lsu_write_ready[lane_r] <= 1'b1;
                        end
                    end
                end
                RESPOND: begin
                    if (release_s) begin
                        lsu_read_ready[lane_r]  <= 1'b0;
                        lsu_write_ready[lane_r] <= 1'b0;
                        ptr_r <= (lane_r == PTR_W'(THREADS - 1)) ? {PTR_W{1'b0}} : lane_r + PTR_W'(1);
                    end
                end
                default: begin
                    op_r <= op_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_lsu_mem_arbiter.sv
// Directed self-checking bench for core_lsu_mem_arbiter with a small L1 model
// that answers each strobe with a one-cycle ready in the following cycle.
module tb_core_lsu_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  rv, wv;
    logic [14:0] ra [4];
    logic [14:0] wa [4];
    logic [7:0]  wd [4];
    logic [59:0] lsu_read_address, lsu_write_address;
    logic [31:0] lsu_write_data;
    logic [3:0]  lsu_read_ready, lsu_write_ready;
    logic [31:0] lsu_read_data;
    logic        mem_read_valid, mem_write_valid;
    logic [14:0] mem_read_address, mem_write_address;
    logic [7:0]  mem_write_data;
    logic        mem_read_ready, mem_write_ready;
    logic [7:0]  mem_read_data;
    logic        mem_timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  l1_mem [0:32767];
    logic        rd_pend, wr_pend, model_en;
    logic [14:0] rd_addr_q;
    logic [15:0] strobe_q [$];
    int          grant_q [$];
    logic [7:0]  rdata_seen [4];

    assign lsu_read_address  = {ra[3], ra[2], ra[1], ra[0]};
    assign lsu_write_address = {wa[3], wa[2], wa[1], wa[0]};
    assign lsu_write_data    = {wd[3], wd[2], wd[1], wd[0]};

`ifndef CORE_LSU_ARB_TIMEOUT_EN
    assign mem_timeout_err = 1'b0;
`endif

    core_lsu_mem_arbiter dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .lsu_read_valid    (rv),
        .lsu_read_address  (lsu_read_address),
        .lsu_write_valid   (wv),
        .lsu_write_address (lsu_write_address),
        .lsu_write_data    (lsu_write_data),
        .lsu_read_ready    (lsu_read_ready),
        .lsu_read_data     (lsu_read_data),
        .lsu_write_ready   (lsu_write_ready),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
`ifdef CORE_LSU_ARB_TIMEOUT_EN
        .mem_timeout_err   (mem_timeout_err),
`endif
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .mem_write_ready   (mem_write_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] rdata(input int lane);
        return lsu_read_data[lane*8 +: 8];
    endfunction

    // L1 model and strobe monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        mem_read_ready  = rd_pend;
        mem_read_data   = rd_pend ? l1_mem[rd_addr_q] : 8'h00;
        mem_write_ready = wr_pend;
        rd_pend   = mem_read_valid && model_en;
        rd_addr_q = mem_read_address;
        wr_pend   = mem_write_valid && model_en;
        if (mem_write_valid) l1_mem[mem_write_address] = mem_write_data;
        if (mem_read_valid)  strobe_q.push_back({1'b0, mem_read_address});
        if (mem_write_valid) strobe_q.push_back({1'b1, mem_write_address});
        if (mem_read_valid || mem_write_valid)
            check_eq("mem_valid_mutex", {31'd0, mem_read_valid & mem_write_valid}, 32'd0);
    end

    task automatic reset_dut();
        reset_n = 1'b0;
        rv = 4'd0;
        wv = 4'd0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    // Plays the LSU side: drop each valid on the first ready cycle, log grants.
    task automatic serve(input int max_cycles);
        int n;
        n = 0;
        while (((rv | wv) != 4'd0) && (n < max_cycles)) begin
            tick(1);
            n++;
            for (int i = 0; i < 4; i++) begin
                if (lsu_read_ready[i] && rv[i]) begin
                    rv[i] = 1'b0;
                    grant_q.push_back(i);
                    rdata_seen[i] = rdata(i);
                end
                if (lsu_write_ready[i] && wv[i]) wv[i] = 1'b0;
            end
        end
        check_eq("serve_complete", {28'd0, rv | wv}, 32'd0);
        tick(1);
    endtask

    task automatic wait_rready(input int lane);
        int n;
        n = 0;
        while (!lsu_read_ready[lane] && (n < 50)) begin
            tick(1);
            n++;
        end
        check_eq("wait_rready", {31'd0, lsu_read_ready[lane]}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no end, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [15:0] s0, s1;
        int sc;
        reset_n  = 1'b0;
        rv = 4'd0; wv = 4'd0;
        for (int i = 0; i < 4; i++) begin
            ra[i] = 15'd0; wa[i] = 15'd0; wd[i] = 8'd0; rdata_seen[i] = 8'd0;
        end
        rd_pend = 1'b0; wr_pend = 1'b0; model_en = 1'b1; rd_addr_q = 15'd0;
        mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = 8'd0;
        reset_dut();

        check_eq("rst_mem_rv",   {31'd0, mem_read_valid}, 32'd0);
        check_eq("rst_mem_wv",   {31'd0, mem_write_valid}, 32'd0);
        check_eq("rst_lsu_rr",   {28'd0, lsu_read_ready}, 32'd0);
        check_eq("rst_lsu_wr",   {28'd0, lsu_write_ready}, 32'd0);
        check_eq("rst_lsu_data", lsu_read_data, 32'd0);
        check_eq("rst_mem_addr", {2'd0, mem_read_address, mem_write_address}, 32'd0);
        check_eq("rst_timeout",  {31'd0, mem_timeout_err}, 32'd0);

        // Single read, lane 0
        l1_mem[15'h0010] = 8'hA5;
        strobe_q.delete();
        ra[0] = 15'h0010; rv[0] = 1'b1;
        tick(1);
        check_eq("rd_strobe_t1", {31'd0, mem_read_valid}, 32'd1);
        check_eq("rd_addr_t1",   {17'd0, mem_read_address}, 32'h0010);
        check_eq("wr_strobe_t1", {31'd0, mem_write_valid}, 32'd0);
        tick(1);
        check_eq("rd_strobe_t2", {31'd0, mem_read_valid}, 32'd0);
        check_eq("rready_t2",    {28'd0, lsu_read_ready}, 32'd0);
        tick(1);
        check_eq("rready_t3",    {28'd0, lsu_read_ready}, 32'h1);
        check_eq("rdata_t3",     {24'd0, rdata(0)}, 32'hA5);
        rv[0] = 1'b0;
        tick(1);
        check_eq("rready_clr",   {28'd0, lsu_read_ready}, 32'd0);
        check_eq("rdata_hold",   {24'd0, rdata(0)}, 32'hA5);
        check_eq("single_strobe_cnt", strobe_q.size(), 32'd1);

        // Full contention from pointer 0, two rounds
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            ra[i] = 15'h0100 + 15'(i);
            l1_mem[15'h0100 + 15'(i)] = 8'h50 + 8'(i);
        end
        grant_q.delete();
        rv = 4'hF;
        serve(100);
        check_eq("rr_count", grant_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("rr_order", (grant_q.size() > i) ? grant_q[i] : -1, i);
            check_eq("rr_data", {24'd0, rdata_seen[i]}, 32'h50 + i);
        end
        grant_q.delete();
        rv = 4'hF;
        serve(100);
        check_eq("rr_wrap_first", (grant_q.size() > 0) ? grant_q[0] : -1, 32'd0);

        // Same-lane write then read on lane 2
        strobe_q.delete();
        wa[2] = 15'h7FFF; wd[2] = 8'h3C; ra[2] = 15'h7FFF;
        wv[2] = 1'b1; rv[2] = 1'b1;
        serve(100);
        s0 = (strobe_q.size() > 0) ? strobe_q[0] : 16'h0000;
        s1 = (strobe_q.size() > 1) ? strobe_q[1] : 16'h0000;
        check_eq("wr_rd_count",  strobe_q.size(), 32'd2);
        check_eq("wr_first",     {16'd0, s0}, 32'hFFFF);
        check_eq("rd_second",    {16'd0, s1}, 32'h7FFF);
        check_eq("wr_rd_data",   {24'd0, rdata_seen[2]}, 32'h3C);

        // Held ready on lane 1 blocks a pending lane 3 request
        l1_mem[15'h0020] = 8'h77;
        l1_mem[15'h0030] = 8'h99;
        ra[1] = 15'h0020; rv[1] = 1'b1;
        wait_rready(1);
        sc = strobe_q.size();
        ra[3] = 15'h0030; rv[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check_eq("held_ready",   {31'd0, lsu_read_ready[1]}, 32'd1);
            check_eq("held_no_issue", strobe_q.size(), sc);
        end
        rv[1] = 1'b0;
        tick(1);
        check_eq("held_release", {31'd0, lsu_read_ready[1]}, 32'd0);
        grant_q.delete();
        serve(50);
        check_eq("after_hold_lane", (grant_q.size() > 0) ? grant_q[0] : -1, 32'd3);
        check_eq("after_hold_data", {24'd0, rdata_seen[3]}, 32'h99);
        check_eq("lane1_undisturbed", {24'd0, rdata(1)}, 32'h77);

`ifdef CORE_LSU_ARB_TIMEOUT_EN
        // Watchdog: L1 never answers
        reset_dut();
        ra[0] = 15'h0010; rv[0] = 1'b1;
        serve(50);
        check_eq("wd_pre_data", {24'd0, rdata(0)}, 32'hA5);
        model_en = 1'b0;
        rv[0] = 1'b1;
        tick(17);
        check_eq("wd_not_yet", {28'd0, lsu_read_ready}, 32'd0);
        tick(1);
        check_eq("wd_ready",   {28'd0, lsu_read_ready}, 32'h1);
        check_eq("wd_data",    {24'd0, rdata(0)}, 32'h00);
        check_eq("wd_err",     {31'd0, mem_timeout_err}, 32'd1);
        rv[0] = 1'b0;
        tick(3);
        check_eq("wd_err_sticky", {31'd0, mem_timeout_err}, 32'd1);
        model_en = 1'b1;
        reset_dut();
        check_eq("wd_err_reset", {31'd0, mem_timeout_err}, 32'd0);
`endif

        // Reset in the middle of WAIT
        reset_dut();
        ra[0] = 15'h0010; rv[0] = 1'b1;
        serve(50);
        ra[2] = 15'h0040; rv[2] = 1'b1;
        tick(2);
        check_eq("pre_rst_wait", {31'd0, mem_read_valid}, 32'd0);
        reset_n = 1'b0;
        rv = 4'd0;
        #1;
        check_eq("async_rst_rr",   {28'd0, lsu_read_ready}, 32'd0);
        check_eq("async_rst_data", lsu_read_data, 32'd0);
        check_eq("async_rst_addr", {17'd0, mem_read_address}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check_eq("post_rst_no_resp", {28'd0, lsu_read_ready}, 32'd0);
        grant_q.delete();
        ra[0] = 15'h0010; ra[1] = 15'h0020;
        rv = 4'b0011;
        serve(100);
        check_eq("post_rst_first", (grant_q.size() > 0) ? grant_q[0] : -1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
